// File: rtl/regfile_ctrl_pkg.sv
// Shared encodings and sizes for the register file arbiter.
// The FSM state type maps onto the fixed 2-bit state codes.
package regfile_ctrl_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int RF_DEPTH  = 8;
    localparam int RF_WIDTH  = 16;
    localparam int RF_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_WRITE = WRITE,
        ST_READ  = READ,
        ST_RESP  = RESP
    } state_t;

    // Width of a requester index; at least one bit even for NREQ=2.
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr,
// searching cyclically.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  win,
    output logic [PTR_W-1:0] win_idx,
    output logic             any
);

    always_comb begin
        int j;
        logic [PTR_W-1:0] idx;
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        j       = 0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            idx = PTR_W'(j);
            if (!any && req[idx]) begin
                any      = 1'b1;
                win[idx] = 1'b1;
                win_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin controller sharing one register file among NREQ requesters;
// sequences wrEN/rdEN/address/wrData and returns read data with a one-hot valid.
module regfile_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 3,
    parameter int RF_ADDR_W = regfile_ctrl_pkg::RF_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]  req_wdata,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [WIDTH-1:0]       rsp_rdata,
    output logic                   rf_wrEN,
    output logic                   rf_rdEN,
    output logic [RF_ADDR_W-1:0]   rf_address,
    output logic [WIDTH-1:0]       rf_wrData,
    input  logic [WIDTH-1:0]       rf_rdData
);
    import regfile_ctrl_pkg::*;

    localparam int PTR_W = ptr_w(NREQ);

    state_t           state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] cur;
    logic [NREQ-1:0]  win;
    logic [PTR_W-1:0] win_idx;
    logic             any;

    rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    // The rf pins are registered and double as the latched transaction:
    // address and write data stay put until the enable drops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            cur        <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rf_wrEN    <= 1'b0;
            rf_rdEN    <= 1'b0;
            rf_address <= '0;
            rf_wrData  <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        cur        <= win_idx;
                        gnt        <= win;
                        ptr        <= (win_idx == PTR_W'(NREQ-1)) ? '0 : win_idx + 1'b1;
                        rf_address <= RF_ADDR_W'(req_addr[win_idx*ADDR_W +: ADDR_W]);
                        if (req_we[win_idx]) begin
                            rf_wrEN   <= 1'b1;
                            rf_wrData <= req_wdata[win_idx*WIDTH +: WIDTH];
                            state     <= ST_WRITE;
                        end else begin
                            rf_rdEN <= 1'b1;
                            state   <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    rf_wrEN    <= 1'b0;
                    rf_wrData  <= '0;
                    rf_address <= '0;
                    state      <= ST_IDLE;
                end
                ST_READ: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    rf_rdEN        <= 1'b0;
                    rf_address     <= '0;
                    rsp_rdata      <= rf_rdData;
                    rsp_valid[cur] <= 1'b1;
                    state          <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 8x16 register file
// (registered read, reset to zero) and an independent expected-value table.
module tb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [3:0]  req_we = '0;
    logic [11:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  gnt;
    logic [3:0]  rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rf_wrEN;
    logic        rf_rdEN;
    logic [15:0] rf_address;
    logic [15:0] rf_wrData;
    logic [15:0] rf_rdData;

    int checks = 0;
    int errors = 0;
    bit overlap_seen = 1'b0;

    always #5 clk = ~clk;

    regfile_arbiter #(.NREQ(4), .WIDTH(16), .ADDR_W(3), .RF_ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rf_wrEN    (rf_wrEN),
        .rf_rdEN    (rf_rdEN),
        .rf_address (rf_address),
        .rf_wrData  (rf_wrData),
        .rf_rdData  (rf_rdData)
    );

    logic [15:0] mem [8];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) mem[i] <= '0;
            rf_rdData <= '0;
        end else begin
            if (rf_wrEN) mem[rf_address[2:0]] <= rf_wrData;
            if (rf_rdEN) rf_rdData <= mem[rf_address[2:0]];
        end
    end

    always @(negedge clk) if (rf_wrEN && rf_rdEN) overlap_seen = 1'b1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Issue one transaction from requester i and report what was observed.
    task automatic do_txn(input int i, input bit we, input logic [2:0] a, input logic [15:0] d,
                          output logic [3:0] g, output int glat, output logic wen, output logic ren,
                          output logic [15:0] wdo, output logic [15:0] ado,
                          output logic [3:0] rv, output logic [15:0] rd, output int rlat);
        req[i] = 1'b1;
        req_we[i] = we;
        req_addr[i*3 +: 3] = a;
        req_wdata[i*16 +: 16] = d;
        g = '0; glat = 0; wen = 0; ren = 0; wdo = '0; ado = '0; rv = '0; rd = '0; rlat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (gnt != 0) begin
                glat = c; g = gnt; wen = rf_wrEN; ren = rf_rdEN; wdo = rf_wrData; ado = rf_address;
                break;
            end
        end
        req[i] = 1'b0;
        if (!we && glat != 0) begin
            for (int c = 1; c <= 20; c++) begin
                @(posedge clk); #1;
                if (rsp_valid != 0) begin
                    rlat = c; rv = rsp_valid; rd = rsp_rdata;
                    break;
                end
            end
        end else begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_rdata, rf_wrEN, rf_rdEN, rf_address, rf_wrData} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%h rv=%h rd=%h we=%b re=%b a=%h wd=%h, expected all 0",
                     gnt, rsp_valid, rsp_rdata, rf_wrEN, rf_rdEN, rf_address, rf_wrData);
        end
        checks++;
        if (dut.state !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d, expected 0", dut.state);
        end
        rst = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] g, rv; int glat, rlat; logic wen, ren; logic [15:0] wdo, ado, rd;
        do_txn(0, 1'b1, 3'd0, 16'h0005, g, glat, wen, ren, wdo, ado, rv, rd, rlat);
        checks++;
        if (g !== 4'b0001 || glat != 1) begin
            errors++;
            $display("FAIL single_wr_gnt: got gnt=%b lat=%0d, expected 0001 lat=1", g, glat);
        end
        checks++;
        if (wen !== 1'b1 || ren !== 1'b0 || wdo !== 16'h0005 || ado !== 16'h0000) begin
            errors++;
            $display("FAIL single_wr_pins: got we=%b re=%b wd=%h a=%h, expected 1 0 0005 0000", wen, ren, wdo, ado);
        end
        do_txn(0, 1'b0, 3'd0, 16'h0000, g, glat, wen, ren, wdo, ado, rv, rd, rlat);
        checks++;
        if (g !== 4'b0001 || ren !== 1'b1 || wen !== 1'b0) begin
            errors++;
            $display("FAIL single_rd_gnt: got gnt=%b re=%b we=%b, expected 0001 1 0", g, ren, wen);
        end
        checks++;
        if (rv !== 4'b0001 || rlat != 2 || rd !== 16'h0005) begin
            errors++;
            $display("FAIL single_rd_rsp: got rv=%b lat=%0d rd=%h, expected 0001 2 0005", rv, rlat, rd);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] g, rv; int glat, rlat; logic wen, ren; logic [15:0] wdo, ado, rd;
        int exp_i;
        logic [15:0] exp_d;
        // Fresh start so requester 0 is first; preload reg i with 0x10+i.
        do_reset();
        for (int i = 0; i < 4; i++)
            do_txn(i, 1'b1, 3'(i), 16'h0010 + 16'(i), g, glat, wen, ren, wdo, ado, rv, rd, rlat);
        for (int i = 0; i < 4; i++) begin
            req_we[i] = 1'b0;
            req_addr[i*3 +: 3] = 3'(i);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_i = k % 4;
            exp_d = 16'h0010 + 16'(exp_i);
            g = '0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (gnt != 0) begin g = gnt; break; end
            end
            if (k == 4) req = '0;
            checks++;
            if (g !== 4'(1 << exp_i)) begin
                errors++;
                $display("FAIL rr_gnt_%0d: got %b, expected %b", k, g, 4'(1 << exp_i));
            end
            rv = '0; rd = '0;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk); #1;
                if (rsp_valid != 0) begin rv = rsp_valid; rd = rsp_rdata; break; end
            end
            checks++;
            if (rv !== 4'(1 << exp_i) || rd !== exp_d) begin
                errors++;
                $display("FAIL rr_rsp_%0d: got rv=%b rd=%h, expected %b %h", k, rv, rd, 4'(1 << exp_i), exp_d);
            end
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_contention();
        logic [3:0] g1, g2, rv; logic w1; logic [15:0] rd;
        do_reset();
        req_we[1] = 1'b1; req_addr[5:3] = 3'd1; req_wdata[31:16] = 16'h000D;
        req_we[2] = 1'b0; req_addr[8:6] = 3'd1;
        req = 4'b0110;
        g1 = '0; w1 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (gnt != 0) begin g1 = gnt; w1 = rf_wrEN; break; end
        end
        req[1] = 1'b0;
        checks++;
        if (g1 !== 4'b0010 || w1 !== 1'b1) begin
            errors++;
            $display("FAIL cont_first: got gnt=%b we=%b, expected 0010 1", g1, w1);
        end
        g2 = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (gnt != 0) begin g2 = gnt; break; end
        end
        req[2] = 1'b0;
        checks++;
        if (g2 !== 4'b0100) begin
            errors++;
            $display("FAIL cont_second: got gnt=%b, expected 0100", g2);
        end
        rv = '0; rd = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (rsp_valid != 0) begin rv = rsp_valid; rd = rsp_rdata; break; end
        end
        checks++;
        if (rv !== 4'b0100 || rd !== 16'h000D) begin
            errors++;
            $display("FAIL cont_read: got rv=%b rd=%h, expected 0100 000d", rv, rd);
        end
    endtask

    task automatic test_multi();
        logic [3:0] g, rv; int glat, rlat; logic wen, ren; logic [15:0] wdo, ado, rd;
        logic [2:0]  addrs [3] = '{3'd1, 3'd5, 3'd7};
        logic [15:0] vals  [3] = '{16'd13, 16'd25, 16'd9};
        overlap_seen = 1'b0;
        for (int i = 0; i < 3; i++)
            do_txn(i + 1, 1'b1, addrs[i], vals[i], g, glat, wen, ren, wdo, ado, rv, rd, rlat);
        for (int i = 0; i < 3; i++) begin
            do_txn(i, 1'b0, addrs[i], 16'h0000, g, glat, wen, ren, wdo, ado, rv, rd, rlat);
            checks++;
            if (rv !== 4'(1 << i) || rd !== vals[i] || ado !== 16'(addrs[i])) begin
                errors++;
                $display("FAIL multi_rd_%0d: got rv=%b rd=%0d a=%0d, expected %b %0d %0d",
                         i, rv, rd, ado, 4'(1 << i), vals[i], addrs[i]);
            end
        end
        checks++;
        if (overlap_seen !== 1'b0) begin
            errors++;
            $display("FAIL enable_overlap: got wrEN&rdEN together, expected never");
        end
    endtask

    task automatic test_reset_mid_read();
        logic [3:0] g, rv; int glat, rlat; logic wen, ren; logic [15:0] wdo, ado, rd;
        req_we[0] = 1'b0; req_addr[2:0] = 3'd5;
        req[0] = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (dut.state !== 2'd3) begin
            errors++;
            $display("FAIL mid_in_resp: got state %0d, expected 3", dut.state);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({gnt, rsp_valid, rsp_rdata, rf_wrEN, rf_rdEN, rf_address, rf_wrData} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got gnt=%h rv=%h rd=%h we=%b re=%b a=%h wd=%h, expected all 0",
                     gnt, rsp_valid, rsp_rdata, rf_wrEN, rf_rdEN, rf_address, rf_wrData);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL mid_no_rsp: got rv=%b, expected 0000", rsp_valid);
        end
        do_txn(0, 1'b0, 3'd0, 16'h0000, g, glat, wen, ren, wdo, ado, rv, rd, rlat);
        checks++;
        if (rv !== 4'b0001 || rd !== 16'h0000) begin
            errors++;
            $display("FAIL mid_after_read: got rv=%b rd=%h, expected 0001 0000", rv, rd);
        end
    endtask

    task automatic test_no_request();
        int bad;
        req = '0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (dut.state !== 2'd0 || gnt !== 4'b0000 || rf_wrEN !== 1'b0 || rf_rdEN !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 3)
                    $display("FAIL idle_cycle_%0d: got state=%0d gnt=%b we=%b re=%b, expected 0 0000 0 0",
                             c, dut.state, gnt, rf_wrEN, rf_rdEN);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_contention();
        test_multi();
        test_reset_mid_read();
        test_no_request();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Round-robin controller that shares one 8x16 register file among NREQ requesters. Each requester issues single read or write transactions over a req/gnt handshake. The block sequences the register file's wrEN/rdEN/address/wrData pins and returns read data with a one-hot valid. It sits between the requesting engines and the register file instance; nothing else drives the register file.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, data width, equal to register file word width
- ADDR_W, 3, register index width (8 registers)
- RF_ADDR_W, 16, width of the register file address port; upper bits are driven 0

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset; also tied to the register file reset
- req  in  NREQ  per-requester transaction request
- req_we  in  NREQ  1 = write, 0 = read
- req_addr  in  NREQ*ADDR_W  packed; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NREQ*WIDTH  packed write data
- gnt  out  NREQ  one-hot, 1-cycle pulse; the transaction has been accepted
- rsp_valid  out  NREQ  one-hot, 1-cycle pulse; read data is available
- rsp_rdata  out  WIDTH  read data, valid while rsp_valid != 0
- rf_wrEN  out  1  register file write enable
- rf_rdEN  out  1  register file read enable
- rf_address  out  RF_ADDR_W  zero-extended register index
- rf_wrData  out  WIDTH  register file write data
- rf_rdData  in  WIDTH  register file read data

## Operation
- FSM states: IDLE, WRITE, READ, RESP.
- **IDLE**
  - `req` is sampled only in this state.
  - If any bit of `req` is set, the winner is the first set bit at or after `ptr`, searching cyclically.
  - On the clock edge the block latches the winner's we/addr/wdata and pulses `gnt[winner]` for the next cycle.
  - `ptr` becomes (winner+1) mod NREQ.
  - Next state is WRITE if we=1, otherwise READ.
- **WRITE**
  - Drives `rf_wrEN`=1 with the latched address and data.
  - Next state is IDLE.
- **READ**
  - Drives `rf_rdEN`=1 with the latched address.
  - Next state is RESP.
- **RESP**
  - Holds `rf_rdEN`=1 and the address.
  - Samples `rf_rdData` on the edge and registers it into `rsp_rdata`.
  - Pulses `rsp_valid[winner]` for the next cycle.
  - Next state is IDLE.
- `rf_wrEN` and `rf_rdEN` are never high together. Both are 0 in IDLE.
- `rf_wrData` and `rf_address` are 0 whenever neither enable is asserted.
- Requester obligations:
  - Hold `req`, `req_we`, `req_addr` and `req_wdata` stable until `gnt` is seen.
  - Deassert `req` on the edge that ends the `gnt` cycle, unless it is issuing a new transaction.
- A `req` held high after `gnt` is treated as a new transaction the next time the FSM is in IDLE.
- Starvation-free: any asserted `req` is granted within NREQ arbitrations.

## Timing
- Request sampled in IDLE at cycle N.
- `gnt` is high in cycle N+1.
- Write: `rf_wrEN` is high in N+1. The register file is updated at the end of N+1. The next arbitration happens in N+2, giving 1 write per 2 cycles.
- Read: `rf_rdEN` is high in N+1 and N+2. `rsp_valid` and `rsp_rdata` are valid in N+3.
- The rsp_valid cycle coincides with IDLE, so a new arbitration may be made in that same cycle.
- Reset (`rst`=0 at an edge):
  - Next state is IDLE and `ptr` is 0.
  - `gnt`, `rsp_valid`, `rsp_rdata`, `rf_wrEN`, `rf_rdEN`, `rf_address` and `rf_wrData` are all 0.
  - A pending read response is discarded, with no `rsp_valid`.
  - A write in progress is lost; the register file resets anyway.
- After reset, requester 0 has the highest priority.

## Structure
- Package `regfile_ctrl_pkg` holds:
  - state encoding localparams (IDLE=2'd0, WRITE=2'd1, READ=2'd2, RESP=2'd3)
  - RF_DEPTH=8, RF_WIDTH=16, RF_ADDR_W=16
- Sub-module `rr_pick`: combinational round-robin selector.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot `win`, `win_idx`, `any`.
- The rest of the block (FSM, latches, output registers) is in `regfile_arbiter`.

## Test plan
- **Single write/read:** req[0] writes 0x0005 to reg 0, then reads reg 0.
  - Required: gnt[0] pulses.
  - Required: rsp_valid[0] at N+3 with rsp_rdata=0x0005.
- **Round robin:** req[3:0]=4'b1111 held, all reads.
  - Required: grant order 0,1,2,3,0.
  - Required: each rsp_valid goes to the matching requester.
- **Contention write/read:** req[1] writes 0x000D to reg 1 while req[2] reads reg 1, both in the same cycle.
  - Required: the write is granted first (ptr=0).
  - Required: the read returns 0x000D.
- **Multi-register:** write 0x000D to reg 1, 0x0019 to reg 5 and 0x0009 to reg 7, then read all three back.
  - Required: 13, 25 and 9 returned.
  - Required: rf_wrEN and rf_rdEN are never high together.
- **Reset mid-read:** rst=0 during RESP.
  - Required: no rsp_valid.
  - Required: all outputs 0 in the next cycle.
  - Required: a read of reg 0 after reset returns 0x0000.
- **No request:** req=0 for 20 cycles.
  - Required: the FSM stays in IDLE.
  - Required: no enables and no gnt are asserted.
